ext_pipe: RTL and testbench
===========================

# ext_pipe

Parametrised, pipelined extension unit that replaces the single-cycle immediate extender. It handles immediate extension (zero, sign, upper-half placement) and load-data extension (lb/lbu/lh/lhu with byte offset). Results are registered behind a valid/ready handshake with a two-entry skid buffer, so it can sit between decode/memory stages and their consumers without a combinational path through either direction. It also carries a sticky error counter for misaligned or reserved requests.

## Interface
- IMM_W, 16, immediate width; must satisfy DATA_W > IMM_W
- DATA_W, 32, result and load-data width; multiple of 16
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  3  operation, encoding below
- in_imm  in  IMM_W  immediate (ops 0–2)
- in_data  in  DATA_W  raw load word (ops 3–6)
- in_off  in  OFF_W  byte offset, little-endian (ops 3–6)
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_W  result
- out_err  out  1  result is an error (misaligned or reserved op)
- err_cnt  out  8  saturating count of accepted erroneous requests

## Operation
- Op 0 ZEXT: zero-extend in_imm.
- Op 1 SEXT: sign-extend in_imm from bit IMM_W-1.
- Op 2 HIGH: {in_imm, (DATA_W-IMM_W) zeros}.
- Op 3 LB: sign-extend byte in_data[8*off +: 8]. Op 4 LBU: zero-extend the same byte.
- Op 5 LH: sign-extend in_data[8*off +: 16]. Op 6 LHU: zero-extend the same halfword.
  - LH/LHU with in_off[0]=1 is misaligned: out_data=0, out_err=1.
- Op 7 reserved: out_data=0, out_err=1.
- Result is computed combinationally at the input and captured into the output register or skid register.
- Skid FSM:
  - EMPTY: in fire → ONE.
  - ONE: in fire only → TWO; out fire only → EMPTY; both → ONE, output register loads the new result.
  - TWO: out fire → ONE, skid moves to the output register.
- in_ready = (state != TWO); it comes from the registered state only.
- out_valid = (state != EMPTY).
- flush has highest priority: next state EMPTY and the same-cycle input is discarded. A discarded request never increments err_cnt.
- err_cnt increments on each accepted, non-flushed request with error and saturates at 255. Only reset clears it.
- Ordering is strictly FIFO.

## Timing
- Latency is 1 cycle: a request accepted at edge N gives out_valid after N.
- Throughput is 1/cycle while out_ready=1.
- Reset values: state EMPTY, in_ready=1, out_valid=0, out_data=0, out_err=0, err_cnt=0. These apply immediately on rst_n low, independent of clk.
- Reset mid-operation drops all held entries; nothing is replayed.
- out_data and out_err are stable while out_valid & !out_ready.
- Simultaneous flush and out_ready: the output is not considered consumed, but it is dropped all the same.

## Structure
- Package ext_pkg holds:
  - op encodings EXT_ZEXT..EXT_RSVD (3-bit localparams)
  - FSM state encodings S_EMPTY/S_ONE/S_TWO
  - ERR_CNT_MAX=255
- Sub-module ext_core: purely combinational op/imm/data/off → {data, err}, parametrised by IMM_W/DATA_W, instantiated once.
- ext_pipe itself holds the FSM, the two data+err registers, and the counter.

## Test plan
- SEXT in_imm=0x8000; HIGH in_imm=0x1234; ZEXT in_imm=0xFFFF, back-to-back with out_ready=1 → outputs 0xFFFF8000, 0x12340000, 0x0000FFFF on consecutive cycles, each 1 cycle after acceptance.
- LB in_data=0x12803456, off=2 → 0xFFFFFF80. LBU same → 0x00000080. LHU off=2 → 0x00001280. LH in_data=0x80000000, off=2 → 0xFFFF8000.
- LH off=1, then op 7 → both out_data=0, out_err=1, err_cnt=2. Send 300 erroneous requests → err_cnt holds 255.
- Backpressure: out_ready=0, offer A,B,C → A,B accepted, in_ready=0 with C held. Raise out_ready → A,B,C emerge in order, and in_ready returns 1 the cycle after the first out fire.
- Flush in state TWO with in_valid=1 → next cycle out_valid=0, in_ready=1. The flushed input is not counted, even when erroneous.
- Assert rst_n=0 between edges in state TWO → out_valid=0, in_ready=1, err_cnt=0 immediately. After release, a fresh SEXT 0x0001 → 0x00000001.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: shared encodings for the extension pipeline.
//   - EXT_* : 3-bit operation codes presented on in_op
//   - state_t : skid-buffer occupancy states
//   - ERR_CNT_MAX : saturation value of the error counter
package ext_pkg;

  localparam logic [2:0] EXT_ZEXT = 3'd0;
  localparam logic [2:0] EXT_SEXT = 3'd1;
  localparam logic [2:0] EXT_HIGH = 3'd2;
  localparam logic [2:0] EXT_LB   = 3'd3;
  localparam logic [2:0] EXT_LBU  = 3'd4;
  localparam logic [2:0] EXT_LH   = 3'd5;
  localparam logic [2:0] EXT_LHU  = 3'd6;
  localparam logic [2:0] EXT_RSVD = 3'd7;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam int unsigned ERR_CNT_MAX = 255;

endpackage

// File: rtl/ext_core.sv
// ext_core: purely combinational extension datapath.
//   op   : operation code (ext_pkg::EXT_*)
//   imm  : immediate operand (ZEXT/SEXT/HIGH)
//   data : raw load word (LB/LBU/LH/LHU)
//   off  : little-endian byte offset into data
//   res  : extended result (zero on error)
//   err  : misaligned halfword or reserved op
module ext_core
  import ext_pkg::*;
#(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] res,
  output logic              err
);

  logic [OFF_W+2:0] bbase;
  logic [OFF_W+2:0] hbase;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  // Halfword base drops offset bit 0 so the select always stays in range;
  // odd offsets are flagged as errors and never use half_v.
  assign bbase  = {off, 3'b000};
  assign hbase  = bbase & ~(OFF_W+3)'(8);
  assign byte_v = data[bbase +: 8];
  assign half_v = data[hbase +: 16];

  always_comb begin
    res = '0;
    err = 1'b0;
    case (op)
      EXT_ZEXT: res = DATA_W'(imm);
      EXT_SEXT: res = DATA_W'($signed(imm));
      EXT_HIGH: res = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_LB:   res = DATA_W'($signed(byte_v));
      EXT_LBU:  res = DATA_W'(byte_v);
      EXT_LH: begin
        if (off[0]) err = 1'b1;
        else        res = DATA_W'($signed(half_v));
      end
      EXT_LHU: begin
        if (off[0]) err = 1'b1;
        else        res = DATA_W'(half_v);
      end
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered extension unit with a two-entry skid buffer.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous flush, drops held and incoming entries
//   in_valid/in_ready    : request handshake (in_ready from registered state)
//   in_op/in_imm/in_data/in_off : request fields
//   out_valid/out_ready  : result handshake
//   out_data/out_err     : result and error flag
//   err_cnt              : saturating count of accepted erroneous requests
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  state_t state, state_nx;

  logic [DATA_W-1:0] core_res;
  logic              core_err;
  logic [DATA_W-1:0] out_q, skid_q;
  logic              out_err_q, skid_err_q;
  logic              in_fire, out_fire;
  logic              ld_out_new, ld_out_skid, ld_skid;

  ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .op   (in_op),
    .imm  (in_imm),
    .data (in_data),
    .off  (in_off),
    .res  (core_res),
    .err  (core_err)
  );

  assign in_ready  = (state != S_TWO);
  assign out_valid = (state != S_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_q;
  assign out_err   = out_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ld_out_new  = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            state_nx   = S_ONE;
            ld_out_new = 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            ld_out_new = 1'b1;
          end else if (in_fire) begin
            state_nx = S_TWO;
            ld_skid  = 1'b1;
          end else if (out_fire) begin
            state_nx = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_nx    = S_ONE;
            ld_out_skid = 1'b1;
          end
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_err_q  <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      if (ld_out_new) begin
        out_q     <= core_res;
        out_err_q <= core_err;
      end else if (ld_out_skid) begin
        out_q     <= skid_q;
        out_err_q <= skid_err_q;
      end
      if (ld_skid) begin
        skid_q     <= core_res;
        skid_err_q <= core_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (in_fire && !flush && core_err && (err_cnt != 8'(ERR_CNT_MAX))) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;

  ext_pipe #(.IMM_W(16), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .in_data   (in_data),
    .in_off    (in_off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] imm,
                       input logic [31:0] data, input logic [1:0] off);
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    in_data  = data;
    in_off   = off;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_imm = '0; in_data = '0; in_off = '0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3] = '{EXT_SEXT, EXT_HIGH, EXT_ZEXT};
    logic [15:0] imms[3] = '{16'h8000, 16'h1234, 16'hFFFF};
    logic [31:0] exp [3] = '{32'hFFFF8000, 32'h12340000, 32'h0000FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], imms[i], 32'h0, 2'd0);
      cyc();
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_err !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d: valid=%b data=%h err=%b want 1 %h 0", i, out_valid, out_data, out_err, exp[i]);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_loads();
    logic [2:0]  ops [4] = '{EXT_LB, EXT_LBU, EXT_LHU, EXT_LH};
    logic [31:0] dat [4] = '{32'h12803456, 32'h12803456, 32'h12803456, 32'h80000000};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280, 32'hFFFF8000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 16'h0, dat[i], 2'd2);
      cyc();
      checks++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_err !== 1'b0) begin
        errors++; $display("FAIL load_%0d: valid=%b data=%h err=%b want 1 %h 0", i, out_valid, out_data, out_err, exp[i]);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    drive(EXT_LH, 16'h0, 32'h12345678, 2'd1);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_err !== 1'b1) begin
      errors++; $display("FAIL err_misaligned: valid=%b data=%h err=%b want 1 00000000 1", out_valid, out_data, out_err);
    end
    drive(EXT_RSVD, 16'hABCD, 32'hFFFFFFFF, 2'd0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_err !== 1'b1) begin
      errors++; $display("FAIL err_reserved: valid=%b data=%h err=%b want 1 00000000 1", out_valid, out_data, out_err);
    end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL err_cnt_two: got %0d want 2", err_cnt); end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(EXT_ZEXT, 16'h00AA, 32'h0, 2'd0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h000000AA || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_a: valid=%b data=%h ready=%b want 1 000000aa 1", out_valid, out_data, in_ready);
    end
    drive(EXT_ZEXT, 16'h00BB, 32'h0, 2'd0);
    cyc();
    checks++; if (in_ready !== 1'b0 || out_data !== 32'h000000AA) begin
      errors++; $display("FAIL bp_full: ready=%b data=%h want 0 000000aa", in_ready, out_data);
    end
    drive(EXT_ZEXT, 16'h00CC, 32'h0, 2'd0);
    cyc();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h000000AA || out_err !== 1'b0) begin
      errors++; $display("FAIL bp_hold: ready=%b valid=%b data=%h err=%b want 0 1 000000aa 0", in_ready, out_valid, out_data, out_err);
    end
    out_ready = 1'b1;
    cyc();
    checks++; if (out_data !== 32'h000000BB || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_b: data=%h ready=%b want 000000bb 1", out_data, in_ready);
    end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h000000CC) begin
      errors++; $display("FAIL bp_c: valid=%b data=%h want 1 000000cc", out_valid, out_data);
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(EXT_ZEXT, 16'h0011, 32'h0, 2'd0);
    cyc();
    drive(EXT_ZEXT, 16'h0022, 32'h0, 2'd0);
    cyc();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup: in_ready=%b want 0", in_ready); end
    drive(EXT_RSVD, 16'h0, 32'h0, 2'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_two: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    // Empty pipe, in_ready high: the erroneous request would fire but flush discards it.
    cyc();
    checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL flush_discard: valid=%b err_cnt=%0d want 0 2", out_valid, err_cnt);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    drive(EXT_RSVD, 16'h0, 32'h0, 2'd0);
    for (int i = 0; i < 300; i++) cyc();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d want 255", err_cnt); end
    checks++; if (out_err !== 1'b1 || out_data !== 32'h0) begin
      errors++; $display("FAIL err_sat_out: err=%b data=%h want 1 00000000", out_err, out_data);
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat_hold: got %0d want 255", err_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(EXT_ZEXT, 16'h0033, 32'h0, 2'd0);
    cyc();
    drive(EXT_ZEXT, 16'h0044, 32'h0, 2'd0);
    cyc();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL arst_setup: ready=%b valid=%b want 0 1", in_ready, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0 || out_data !== 32'h0) begin
      errors++; $display("FAIL arst_now: valid=%b ready=%b err_cnt=%0d data=%h want 0 1 0 00000000",
                         out_valid, in_ready, err_cnt, out_data);
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_replay: out_valid=%b want 0", out_valid); end
    drive(EXT_SEXT, 16'h0001, 32'h0, 2'd0);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h00000001 || out_err !== 1'b0) begin
      errors++; $display("FAIL arst_fresh: valid=%b data=%h err=%b want 1 00000001 0", out_valid, out_data, out_err);
    end
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_loads();
    test_errors();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
